// File: rtl/alu_seq.sv
// alu_seq: clocked ALU with start/busy/done handshake,
// multi-cycle shifts, shift-add multiply and sticky flags.
module alu_seq #(
   parameter int WIDTH   = 8,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [5:0]       OPCODE,
   input  logic [WIDTH-1:0] IN1,
   input  logic [WIDTH-1:0] IN2,
   output logic [WIDTH-1:0] result,
   output logic             overflow,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic             halted
);
   localparam int CW = SHAMT_W + 1;
   localparam int AW = 2 * WIDTH;

   typedef enum logic {IDLE, RUN} state_t;
   typedef enum logic [1:0] {
      K_LSL,
      K_LSR,
      K_MUL
   } kind_t;

   state_t state;
   kind_t  kind;
   kind_t  n_kind;

   logic [CW-1:0]      cnt;
   logic [CW-1:0]      n_cnt;
   logic [WIDTH-1:0]   mcand;
   logic [AW-1:0]      acc;
   logic [AW-1:0]      step_acc;
   logic               step_out;
   logic [WIDTH:0]     psum;

   logic [2:0]         op;
   logic [2:0]         fn;
   logic [SHAMT_W-1:0] shamt;
   logic               accept;

   assign op     = OPCODE[5:3];
   assign fn     = OPCODE[2:0];
   assign shamt  = IN1[SHAMT_W-1:0];
   assign accept = start & ~busy & ~halted;

   logic is_add;
   logic is_match;
   logic is_lt;
   logic is_dist;
   logic is_grp;

   assign is_add   = (op == 3'b010);
   assign is_match = (op == 3'b011);
   assign is_lt    = (op == 3'b100);
   assign is_dist  = (op == 3'b101);
   assign is_grp   = (op == 3'b110);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] mag;

   assign sum  = {1'b0, IN1} + {1'b0, IN2};
   assign diff = {IN1[WIDTH-1], IN1}
               - {IN2[WIDTH-1], IN2};
   // only the low bits of |diff| survive; 2^WIDTH never occurs
   assign mag  = diff[WIDTH]
               ? (~diff[WIDTH-1:0] + WIDTH'(1))
               : diff[WIDTH-1:0];

   logic             wr_res;
   logic             wr_ov;
   logic             go_run;
   logic             set_halt;
   logic             bad;
   logic [WIDTH-1:0] n_res;
   logic             n_ov;

   always_comb begin
      wr_res   = 1'b0;
      wr_ov    = 1'b0;
      go_run   = 1'b0;
      set_halt = 1'b0;
      bad      = 1'b0;
      n_res    = result;
      n_ov     = overflow;
      n_kind   = K_LSL;
      n_cnt    = '0;
      unique case (1'b1)
         is_add: begin
            n_res  = sum[WIDTH-1:0];
            n_ov   = sum[WIDTH];
            wr_res = 1'b1;
            wr_ov  = 1'b1;
         end
         is_match: begin
            n_ov  = (IN1 == IN2);
            wr_ov = 1'b1;
         end
         is_lt: begin
            n_ov  = $signed(IN1) < $signed(IN2);
            wr_ov = 1'b1;
         end
         is_dist: begin
            n_res  = mag;
            wr_res = 1'b1;
         end
         is_grp: begin
            unique case (fn)
               3'b000, 3'b001: begin
                  if (shamt == '0) begin
                     n_res  = IN2;
                     n_ov   = 1'b0;
                     wr_res = 1'b1;
                     wr_ov  = 1'b1;
                  end else begin
                     go_run = 1'b1;
                     n_kind = fn[0] ? K_LSR : K_LSL;
                     n_cnt  = {1'b0, shamt};
                  end
               end
               3'b010: begin
                  n_res  = IN2 + WIDTH'(1);
                  wr_res = 1'b1;
               end
               3'b011: begin
                  n_ov  = IN2[0];
                  wr_ov = 1'b1;
               end
               3'b100: begin
                  n_ov  = (IN2 == '0);
                  wr_ov = 1'b1;
               end
               3'b101: begin
                  n_res  = '0;
                  wr_res = 1'b1;
               end
               3'b110: begin
                  go_run = 1'b1;
                  n_kind = K_MUL;
                  n_cnt  = CW'(WIDTH);
               end
               3'b111: set_halt = 1'b1;
            endcase
         end
         default: bad = 1'b1;
      endcase
   end

   // one shift or one shift-add step per edge
   always_comb begin
      step_acc = acc;
      step_out = 1'b0;
      psum     = '0;
      unique case (kind)
         K_LSL: begin
            step_out = acc[WIDTH-1];
            step_acc = {{WIDTH{1'b0}},
                        acc[WIDTH-2:0], 1'b0};
         end
         K_LSR: begin
            step_out = acc[0];
            step_acc = {{WIDTH{1'b0}},
                        1'b0, acc[WIDTH-1:1]};
         end
         K_MUL: begin
            psum = {1'b0, acc[AW-1:WIDTH]}
                 + (acc[0] ? {1'b0, mcand} : '0);
            step_acc = {psum, acc[WIDTH-1:1]};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         kind     <= K_LSL;
         cnt      <= '0;
         mcand    <= '0;
         acc      <= '0;
         result   <= '0;
         overflow <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         halted   <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (accept) begin
                  if (go_run) begin
                     state <= RUN;
                     busy  <= 1'b1;
                     kind  <= n_kind;
                     cnt   <= n_cnt;
                     mcand <= IN1;
                     acc   <= {{WIDTH{1'b0}}, IN2};
                  end else begin
                     done <= 1'b1;
                     err  <= bad;
                     if (wr_res) result <= n_res;
                     if (wr_ov) overflow <= n_ov;
                     if (set_halt) halted <= 1'b1;
                  end
               end
            end
            RUN: begin
               acc <= step_acc;
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  state  <= IDLE;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  result <= step_acc[WIDTH-1:0];
                  overflow <= (kind == K_MUL)
                            ? |step_acc[AW-1:WIDTH]
                            : step_out;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
